// File: rtl/vga_pkg.sv
// Default 640x480@60 raster constants and shared types for the VGA timing path.
package vga_pkg;

  localparam int DEF_CORDW    = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_FCW      = 16;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [DEF_CORDW-1:0] coord_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow level signals crossing into the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_timing_480p.sv
// Raster timing generator: counters, syncs, data-enable, strobes and frame count.
// Waits in IDLE until the synchronised pixel-clock lock is seen, then free-runs.
module vga_timing_480p
  import vga_pkg::*;
#(
  parameter int   CORDW    = DEF_CORDW,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   FCW      = DEF_FCW
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             clk_pix_locked,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic [FCW-1:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST  = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST  = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT   = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT   = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_BEG  = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END  = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_BEG  = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END  = CORDW'(V_ACTIVE + V_FP + V_SYNC);

  logic             lk;
  vga_state_e       state_q, state_d;
  logic             run_d;
  logic [CORDW-1:0] sx_d, sy_d;
  logic             hsync_d, vsync_d, de_d, line_d, frame_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk_pix),
    .rst_n (rst_n),
    .d     (clk_pix_locked),
    .q     (lk)
  );

  always_comb begin
    state_d     = state_q;
    run_d       = 1'b0;
    sx_d        = '0;
    sy_d        = '0;
    frame_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (lk) begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          state_d = ST_IDLE;
        end else begin
          run_d       = 1'b1;
          frame_cnt_d = frame_cnt_q;
          if (sx == H_LAST) begin
            sy_d = (sy == V_LAST) ? '0 : sy + 1'b1;
            if (sy == V_LAST) frame_cnt_d = frame_cnt_q + 1'b1;
          end else begin
            sx_d = sx + 1'b1;
            sy_d = sy;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode from the next-state counters so registered syncs line up with sx/sy.
  always_comb begin
    hsync_d = (run_d && sx_d >= HS_BEG && sx_d < HS_END) ? H_POL : ~H_POL;
    vsync_d = (run_d && sy_d >= VS_BEG && sy_d < VS_END) ? V_POL : ~V_POL;
    de_d    = run_d && (sx_d < H_ACT) && (sy_d < V_ACT);
    line_d  = run_d && (sx_d == '0);
    frame_d = line_d && (sy_d == '0);
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sx          <= '0;
      sy          <= '0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      line        <= 1'b0;
      frame       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sx          <= sx_d;
      sy          <= sy_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      de          <= de_d;
      line        <= line_d;
      frame       <= frame_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule
